// File: rtl/bnn_exec_unit_if.sv
// BNN execute-unit bus: E-stage controls/operands in, stall and result out.
// The pipeline side uses the master modport, the execute unit the slave one.
interface bnn_exec_unit_if #(
    parameter int DATA_W = 32
);
    logic              start_E;
    logic              en_threshold_E;
    logic              ms_WE_E;
    logic              at_WE_E;
    logic [DATA_W-1:0] cfg_val_E;
    logic              flush_E;
    logic [DATA_W-1:0] opA_E;
    logic [DATA_W-1:0] opB_E;
    logic              busy;
    logic              result_valid;
    logic [DATA_W-1:0] result;

    modport master (
        output start_E, en_threshold_E, ms_WE_E, at_WE_E, cfg_val_E,
               flush_E, opA_E, opB_E,
        input  busy, result_valid, result
    );

    modport slave (
        input  start_E, en_threshold_E, ms_WE_E, at_WE_E, cfg_val_E,
               flush_E, opA_E, opB_E,
        output busy, result_valid, result
    );
endinterface

// File: rtl/bnn_exec_unit.sv
// Multi-cycle execute unit for the custom BNN instructions.
// Holds the matrix-size (ms) and activation-threshold (at) registers and
// computes a masked XNOR-popcount over CHUNK_W bits per RUN cycle.
// Optional feature macro: BNN_BIPOLAR_EN -- when defined, the non-threshold
// result is the signed bipolar dot product 2*acc - ms instead of acc.
module bnn_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    bnn_exec_unit_if.slave    bus
);
    localparam int NCH   = DATA_W / CHUNK_W;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACC_W = $clog2(DATA_W + 1);
    localparam logic [5:0] MS_MAX = 6'(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic [5:0]          r_ms;
    logic [5:0]          r_at;
    logic [DATA_W-1:0]   r_x;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_last;
    logic [ACC_W-1:0]    r_acc;
    logic                r_en_th;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_valid;

    logic                w_cfg_wr;
    logic                w_cfg_acc;
    logic                w_start;
    logic [5:0]          w_cfg_v;
    logic [5:0]          w_cfg_ms;
    logic [5:0]          w_cfg_at;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_x;
    logic [IDX_W-1:0]    w_last;
    logic [CHUNK_W-1:0]  w_chunk [NCH];
    logic [CHUNK_W-1:0]  w_sel;
    logic [ACC_W-1:0]    w_pop;
    logic [ACC_W-1:0]    w_acc_next;
    logic [DATA_W-1:0]   w_res_next;
    logic                w_unused_cfg;

    // Only the low six immediate bits carry configuration.
    assign w_cfg_v      = bus.cfg_val_E[5:0];
    assign w_unused_cfg = ^bus.cfg_val_E[DATA_W-1:6];

    // A config write wins over a start in the same cycle; a squashed
    // instruction commits nothing.
    assign w_cfg_wr  = bus.ms_WE_E | bus.at_WE_E;
    assign w_cfg_acc = (r_state == S_IDLE) & w_cfg_wr & ~bus.flush_E;
    assign w_start   = (r_state == S_IDLE) & bus.start_E & ~bus.flush_E & ~w_cfg_wr;

    // Matrix size of 0 is meaningless, so it saturates to the full width too.
    assign w_cfg_ms = ((w_cfg_v == 6'd0) || (w_cfg_v > MS_MAX)) ? MS_MAX : w_cfg_v;
    assign w_cfg_at = (w_cfg_v > MS_MAX) ? MS_MAX : w_cfg_v;

    // Shifting by the full width yields zero, so ms = DATA_W gives all ones.
    assign w_mask = ~({DATA_W{1'b1}} << r_ms);
    assign w_x    = ~(bus.opA_E ^ bus.opB_E) & w_mask;
    assign w_last = IDX_W'(((32'(r_ms) + CHUNK_W - 1) / CHUNK_W) - 1);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
            assign w_chunk[gi] = r_x[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    assign w_sel = w_chunk[r_idx];

    // Popcount of the chunk currently being consumed.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            w_pop = w_pop + ACC_W'(w_sel[i]);
        end
    end

    assign w_acc_next = r_acc + w_pop;

    // Final result formed from the accumulator including the last chunk.
    always_comb begin
        w_res_next = '0;
        if (r_en_th) begin
            w_res_next = {{(DATA_W-1){1'b0}}, (w_acc_next >= r_at)};
        end else begin
`ifdef BNN_BIPOLAR_EN
            w_res_next = (DATA_W'(w_acc_next) << 1) - DATA_W'(r_ms);
`else
            w_res_next = DATA_W'(w_acc_next);
`endif
        end
    end

    // Control FSM, configuration registers and registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ms           <= MS_MAX;
            r_at           <= 6'd0;
            r_x            <= '0;
            r_idx          <= '0;
            r_last         <= '0;
            r_acc          <= '0;
            r_en_th        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_acc) begin
                        if (bus.ms_WE_E) r_ms <= w_cfg_ms;
                        if (bus.at_WE_E) r_at <= w_cfg_at;
                    end else if (w_start) begin
                        r_x     <= w_x;
                        r_last  <= w_last;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_en_th <= bus.en_threshold_E;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.flush_E) begin
                        r_acc   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == r_last) begin
                            r_result       <= w_res_next;
                            r_result_valid <= 1'b1;
                            r_state        <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The held instruction's start is ignored here.
                    if (bus.flush_E) r_acc <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall covers the accepting cycle and every RUN cycle, never DONE.
    assign bus.busy         = w_start | (r_state == S_RUN);
    assign bus.result_valid = r_result_valid & ~bus.flush_E;
    assign bus.result       = r_result;
endmodule

// File: tb/tb_bnn_exec_unit.sv
// Self-checking bench for bnn_exec_unit: directed scenarios plus randomized
// operations compared against a bit-counting reference model.
module tb_bnn_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ms = 32;
    int   m_at = 0;
    logic [31:0] last_result = '0;

    bnn_exec_unit_if #(.DATA_W(32)) bus ();

    bnn_exec_unit #(.DATA_W(32), .CHUNK_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: count agreeing bit positions below ms, then apply the output rule.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic en);
        int cnt = 0;
        for (int i = 0; i < m_ms; i++) if (a[i] == b[i]) cnt++;
        if (en) return (cnt >= m_at) ? 32'd1 : 32'd0;
`ifdef BNN_BIPOLAR_EN
        return 32'(2 * cnt - m_ms);
`else
        return 32'(cnt);
`endif
    endfunction

    task automatic idle_inputs();
        bus.start_E = 0; bus.en_threshold_E = 0; bus.ms_WE_E = 0; bus.at_WE_E = 0;
        bus.cfg_val_E = '0; bus.flush_E = 0; bus.opA_E = '0; bus.opB_E = '0;
    endtask

    task automatic write_cfg(input logic ms_we, input logic at_we, input logic [31:0] val);
        logic [5:0] v;
        v = val[5:0];
        bus.ms_WE_E = ms_we; bus.at_WE_E = at_we; bus.cfg_val_E = val;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL cfg_busy: busy=%0b required 0", bus.busy);
        end
        @(posedge clk); #1;
        bus.ms_WE_E = 0; bus.at_WE_E = 0; bus.cfg_val_E = '0;
        if (ms_we) m_ms = (v == 0 || v > 32) ? 32 : int'(v);
        if (at_we) m_at = (v > 32) ? 32 : int'(v);
    endtask

    // Run one operation, checking busy every cycle, latency and result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic en,
                         input logic [31:0] exp_res, input string name);
        int  exp_lat;
        bit  got;
        exp_lat = (m_ms + 7) / 8 + 1;
        got = 0;
        bus.opA_E = a; bus.opB_E = b; bus.en_threshold_E = en; bus.start_E = 1;
        for (int c = 0; c <= exp_lat + 2 && !got; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.busy !== (c < exp_lat)) begin
                n_fail++;
                $display("FAIL %s_busy: cycle %0d busy=%0b required %0b", name, c, bus.busy, (c < exp_lat));
            end
            if (bus.result_valid === 1'b1) begin
                got = 1;
                n_tests++;
                if (c != exp_lat) begin
                    n_fail++; $display("FAIL %s_latency: valid at cycle %0d required %0d", name, c, exp_lat);
                end
                n_tests++;
                if (bus.result !== exp_res) begin
                    n_fail++; $display("FAIL %s_result: got 0x%08h required 0x%08h", name, bus.result, exp_res);
                end
            end
            @(posedge clk); #1;
            if (got) bus.start_E = 0;
        end
        bus.start_E = 0; bus.en_threshold_E = 0;
        last_result = exp_res;
        $display("[TB] op %s a=%08h b=%08h en=%0b ms=%0d at=%0d exp=%08h", name, a, b, en, m_ms, m_at, exp_res);
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: no result_valid within %0d cycles", name, exp_lat + 3);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== last_result) begin
                n_fail++;
                $display("FAIL %s_quiet: busy=%0b valid=%0b result=0x%08h required 0/0/0x%08h",
                         name, bus.busy, bus.result_valid, bus.result, last_result);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 0 || bus.result_valid !== 0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b valid=%0b result=0x%08h required 0/0/0",
                     bus.busy, bus.result_valid, bus.result);
        end
        @(posedge clk); #1;
        reset = 0;
        m_ms = 32; m_at = 0; last_result = '0;
        expect_quiet(2, "after_reset");
        $display("[TB] reset released");
    endtask

    task automatic test_full_width();
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd32, "full_width");
    endtask

    task automatic test_ms10();
        write_cfg(1, 0, 32'd10);
`ifdef BNN_BIPOLAR_EN
        do_op(32'h0000_00F0, 32'h0, 1'b0, 32'd2, "ms10");
        do_op(32'h0000_03FF, 32'h0, 1'b0, 32'hFFFF_FFF6, "ms10_neg");
`else
        do_op(32'h0000_00F0, 32'h0, 1'b0, 32'd6, "ms10");
`endif
    endtask

    task automatic test_threshold();
        write_cfg(0, 1, 32'd5);
        do_op(32'h0000_00F0, 32'h0, 1'b1, 32'd1, "thr_at5");
        write_cfg(0, 1, 32'd7);
        do_op(32'h0000_00F0, 32'h0, 1'b1, 32'd0, "thr_at7");
        write_cfg(0, 1, 32'd6);
        do_op(32'h0000_00F0, 32'h0, 1'b1, 32'd1, "thr_at6");
    endtask

    task automatic test_saturation();
        write_cfg(1, 0, 32'd0);
        do_op(32'h0, 32'h0, 1'b0, 32'd32, "ms0_sat");
        write_cfg(1, 0, 32'd10);
        write_cfg(1, 0, 32'd40);
        do_op(32'h0, 32'h0, 1'b0, 32'd32, "ms40_sat");
    endtask

    task automatic test_cfg_collision();
        bus.ms_WE_E = 1; bus.cfg_val_E = 32'd10; bus.start_E = 1;
        bus.opA_E = 32'h0000_00F0; bus.opB_E = '0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL collision_busy: busy=%0b required 0", bus.busy);
        end
        @(posedge clk); #1;
        idle_inputs();
        m_ms = 10;
        expect_quiet(6, "collision");
        do_op(32'h0000_00F0, 32'h0, 1'b0, model(32'h0000_00F0, 32'h0, 1'b0), "after_collision");
    endtask

    task automatic test_flush();
        write_cfg(1, 0, 32'd32);
        bus.opA_E = 32'hFFFF_FFFF; bus.opB_E = 32'hFFFF_FFFF; bus.start_E = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start_E = 0; bus.flush_E = 1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_run_busy: busy=%0b required 1", bus.busy);
        end
        @(posedge clk); #1;
        bus.flush_E = 0;
        expect_quiet(6, "flush");
        do_op(32'h1234_5678, 32'h1234_0000, 1'b0, model(32'h1234_5678, 32'h1234_0000, 1'b0), "after_flush");
    endtask

    task automatic test_async_reset();
        bus.opA_E = 32'hA5A5_A5A5; bus.opB_E = 32'h0F0F_0F0F; bus.start_E = 1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1; bus.start_E = 0;
        #1;
        n_tests++;
        if (bus.busy !== 0 || bus.result_valid !== 0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%0b valid=%0b result=0x%08h required 0/0/0",
                     bus.busy, bus.result_valid, bus.result);
        end
        @(posedge clk); #1;
        reset = 0;
        m_ms = 32; m_at = 0; last_result = '0;
        do_op(32'h0000_0000, 32'hFFFF_0000, 1'b1, model(32'h0000_0000, 32'hFFFF_0000, 1'b1), "post_reset_thr");
        do_op(32'hFFFF_0000, 32'h0000_0000, 1'b0, model(32'hFFFF_0000, 32'h0000_0000, 1'b0), "post_reset_ms");
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] a, b, v;
        logic en;
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = 32'($urandom_range(0, 63));
                write_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, v);
            end
            a  = $urandom;
            b  = $urandom;
            en = 1'($urandom_range(0, 1));
            do_op(a, b, en, model(a, b, en), "random");
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_full_width();
        test_ms10();
        test_threshold();
        test_saturation();
        test_cfg_collision();
        test_flush();
        test_async_reset();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
